alu: RTL and testbench

Parameterized N-bit registered arithmetic/logic unit with status flags. It is the compute core of the calculator datapath. Operands `A` and `B` and a 4-bit opcode `sel` are sampled each clock. The result and four flags (zero, overflow, carry/borrow, negative) are registered.

---
 rtl/alu.sv | 150 +++++++++++++++
 tb/tb_alu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered N-bit ALU for the calculator datapath.
// It computes one operation combinationally from A, B and sel, then registers the result and four flags.
module alu #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   sel,
  output logic [N-1:0] out,
  output logic         Z,
  output logic         O,
  output logic         Ca,
  output logic         Neg
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;

  localparam int           SW    = $clog2(N);
  localparam logic [N-1:0] N_VAL = N'(N);

  // Arithmetic datapath
  logic [N:0]     sum_ext;
  logic [N:0]     diff_ext;
  logic [2*N-1:0] prod;
  logic           b_zero;
  logic [N-1:0]   quot;
  logic [N-1:0]   rem;

  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};
  assign prod     = {{N{1'b0}}, A} * {{N{1'b0}}, B};
  assign b_zero   = (B == '0);
  assign quot     = b_zero ? '1 : (A / B);
  assign rem      = b_zero ? A  : (A % B);

  logic add_ovf;
  logic sub_ovf;

  assign add_ovf = (A[N-1] == B[N-1]) && (sum_ext[N-1] != A[N-1]);
  assign sub_ovf = (A[N-1] != B[N-1]) && (diff_ext[N-1] != A[N-1]);

  // Barrel shifters: one stage per bit of the shift amount.
  // Any amount >= N clears the result, so only the low SW bits feed the stages.
  logic [N-1:0] shl_stage [0:SW];
  logic [N-1:0] shr_stage [0:SW];
  logic         shamt_big;
  logic [N-1:0] shl_res;
  logic [N-1:0] shr_res;

  assign shl_stage[0] = A;
  assign shr_stage[0] = A;

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_shift
      assign shl_stage[gi+1] = B[gi] ? (shl_stage[gi] << (1 << gi)) : shl_stage[gi];
      assign shr_stage[gi+1] = B[gi] ? (shr_stage[gi] >> (1 << gi)) : shr_stage[gi];
    end
  endgenerate

  assign shamt_big = (B >= N_VAL);
  assign shl_res   = shamt_big ? '0 : shl_stage[SW];
  assign shr_res   = shamt_big ? '0 : shr_stage[SW];

  // Result and flag selection
  logic [N-1:0] out_d, out_q;
  logic         z_d, z_q;
  logic         o_d, o_q;
  logic         ca_d, ca_q;
  logic         neg_d, neg_q;
  logic         arith;

  always_comb begin
    out_d = '0;
    o_d   = 1'b0;
    ca_d  = 1'b0;
    arith = 1'b0;
    case (sel)
      OP_ADD: begin
        out_d = sum_ext[N-1:0];
        ca_d  = sum_ext[N];
        o_d   = add_ovf;
        arith = 1'b1;
      end
      OP_SUB: begin
        out_d = diff_ext[N-1:0];
        ca_d  = diff_ext[N];
        o_d   = sub_ovf;
        arith = 1'b1;
      end
      OP_MUL: begin
        out_d = prod[N-1:0];
        o_d   = |prod[2*N-1:N];
        arith = 1'b1;
      end
      OP_DIV: begin
        out_d = quot;
        o_d   = b_zero;
        arith = 1'b1;
      end
      OP_MOD: begin
        out_d = rem;
        o_d   = b_zero;
        arith = 1'b1;
      end
      OP_SHL:  out_d = shl_res;
      OP_SHR:  out_d = shr_res;
      OP_AND:  out_d = A & B;
      OP_OR:   out_d = A | B;
      OP_XOR:  out_d = A ^ B;
      default: out_d = '0;
    endcase
    z_d   = arith && (out_d == '0);
    neg_d = arith && out_d[N-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      z_q   <= 1'b0;
      o_q   <= 1'b0;
      ca_q  <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      out_q <= out_d;
      z_q   <= z_d;
      o_q   <= o_d;
      ca_q  <= ca_d;
      neg_q <= neg_d;
    end
  end

  assign out = out_q;
  assign Z   = z_q;
  assign O   = o_q;
  assign Ca  = ca_q;
  assign Neg = neg_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the 4-bit ALU.
// Expected results and flags are hand-computed; the flags are compared as {Z,O,Ca,Neg}.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] sel_in;
  logic [3:0] out_w;
  logic       z_w, o_w, ca_w, neg_w;

  int n_checks = 0;
  int n_fail   = 0;

  alu #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a_in),
    .B   (b_in),
    .sel (sel_in),
    .out (out_w),
    .Z   (z_w),
    .O   (o_w),
    .Ca  (ca_w),
    .Neg (neg_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation, clock it in, and compare one edge later.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] s, input logic [3:0] exp_out,
                        input logic [3:0] exp_flags);
    a_in   = a;
    b_in   = b;
    sel_in = s;
    @(posedge clk);
    #1;
    $display("op %-8s A=%b B=%b sel=%b -> out=%b ZOCN=%b%b%b%b", tag, a, b, s,
             out_w, z_w, o_w, ca_w, neg_w);
    check({tag, ".out"}, {4'h0, out_w}, {4'h0, exp_out});
    check({tag, ".flg"}, {4'h0, z_w, o_w, ca_w, neg_w}, {4'h0, exp_flags});
  endtask

  initial begin
    rst    = 1'b1;
    a_in   = 4'b1111;
    b_in   = 4'b1111;
    sel_in = 4'b0010;
    @(posedge clk);
    #1;
    $display("reset  -> out=%b ZOCN=%b%b%b%b", out_w, z_w, o_w, ca_w, neg_w);
    check("rst.out", {4'h0, out_w}, 8'h00);
    check("rst.flg", {4'h0, z_w, o_w, ca_w, neg_w}, 8'h00);
    rst = 1'b0;

    // add / sub
    run_op("add7+1",  4'b0111, 4'b0001, 4'b0000, 4'b1000, 4'b0101);
    run_op("addD+3",  4'b1101, 4'b0011, 4'b0000, 4'b0000, 4'b1010);
    run_op("addF+1",  4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b1010);
    run_op("sub2-D",  4'b0010, 4'b1101, 4'b0001, 4'b0101, 4'b0010);
    run_op("sub8-1",  4'b1000, 4'b0001, 4'b0001, 4'b0111, 4'b0100);
    run_op("sub5-5",  4'b0101, 4'b0101, 4'b0001, 4'b0000, 4'b1000);
    // mul / div / mod
    run_op("mul3*9",  4'b0011, 4'b1001, 4'b0010, 4'b1011, 4'b0101);
    run_op("mul3*2",  4'b0011, 4'b0010, 4'b0010, 4'b0110, 4'b0000);
    run_op("div6/B",  4'b0110, 4'b1011, 4'b0011, 4'b0000, 4'b1000);
    run_op("divD/3",  4'b1101, 4'b0011, 4'b0011, 4'b0100, 4'b0000);
    run_op("mod3%1",  4'b0011, 4'b0001, 4'b0100, 4'b0000, 4'b1000);
    run_op("modE%4",  4'b1110, 4'b0100, 4'b0100, 4'b0010, 4'b0000);
    run_op("div5/0",  4'b0101, 4'b0000, 4'b0011, 4'b1111, 4'b0101);
    run_op("mod7%0",  4'b0111, 4'b0000, 4'b0100, 4'b0111, 4'b0100);
    run_op("mod9%0",  4'b1001, 4'b0000, 4'b0100, 4'b1001, 4'b0101);
    // shifts
    run_op("shl2<<2", 4'b0010, 4'b0010, 4'b0101, 4'b1000, 4'b0000);
    run_op("shr3>>2", 4'b0011, 4'b0010, 4'b0110, 4'b0000, 4'b0000);
    run_op("shl1<<4", 4'b0001, 4'b0100, 4'b0101, 4'b0000, 4'b0000);
    run_op("shrC>>1", 4'b1100, 4'b0001, 4'b0110, 4'b0110, 4'b0000);
    run_op("shr8>>9", 4'b1000, 4'b1001, 4'b0110, 4'b0000, 4'b0000);
    run_op("shl3<<3", 4'b0011, 4'b0011, 4'b0101, 4'b1000, 4'b0000);
    // logic
    run_op("and",     4'b0110, 4'b1011, 4'b0111, 4'b0010, 4'b0000);
    run_op("or",      4'b0110, 4'b1011, 4'b1000, 4'b1111, 4'b0000);
    run_op("xor",     4'b0110, 4'b1011, 4'b1001, 4'b1101, 4'b0000);
    run_op("xorzero", 4'b0101, 4'b0101, 4'b1001, 4'b0000, 4'b0000);
    // unused opcodes interleaved back-to-back
    run_op("sel1011", 4'b1111, 4'b1111, 4'b1011, 4'b0000, 4'b0000);
    run_op("add7+1b", 4'b0111, 4'b0001, 4'b0000, 4'b1000, 4'b0101);
    run_op("sel1111", 4'b0101, 4'b0011, 4'b1111, 4'b0000, 4'b0000);
    run_op("sel1010", 4'b1111, 4'b0001, 4'b1010, 4'b0000, 4'b0000);

    // The register must hold between edges, even if the inputs change mid-cycle.
    run_op("mul3*9b", 4'b0011, 4'b1001, 4'b0010, 4'b1011, 4'b0101);
    a_in   = 4'b0000;
    b_in   = 4'b0000;
    sel_in = 4'b0000;
    #2;
    check("hold.out", {4'h0, out_w}, 8'h0B);
    check("hold.flg", {4'h0, z_w, o_w, ca_w, neg_w}, 8'h05);

    // Reset has priority over a live operation.
    a_in   = 4'b0111;
    b_in   = 4'b0001;
    sel_in = 4'b0000;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    check("rst2.out", {4'h0, out_w}, 8'h00);
    check("rst2.flg", {4'h0, z_w, o_w, ca_w, neg_w}, 8'h00);
    rst = 1'b0;
    run_op("postrst", 4'b0111, 4'b0001, 4'b0000, 4'b1000, 4'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
